hazard_pipe_tracker: RTL
========================

# hazard_pipe_tracker

Back-end pipeline tracker that consumes the hazard unit's `forward_a`, `forward_b` and `stall` decisions and produces the stage information the hazard unit needs. It holds the EX, MEM and WB pipeline slots: destination register, write enable, load flag and result data for each slot. It selects the forwarded operands latched into EX, inserts bubbles on stall or flush, and drives the register-file write port from WB. It sits between decode and the register file, forming the closed loop with the hazard unit.

## Interface
Parameters:
- `DATA_W`, 16: operand and result width.
- `IGNORE_REG0`, 0: when 1, any instruction with `id_rd == 0` is captured with `reg_write` cleared.

Ports:
- `clk` in 1: single clock, rising edge.
- `rst_n` in 1: asynchronous active-low reset.
- `id_valid` in 1: decode slot holds a real instruction.
- `id_rd` in 2: destination register of the decode instruction.
- `id_reg_write` in 1: decode instruction writes the register file.
- `id_mem_read` in 1: decode instruction is a load.
- `id_rs_data`, `id_rt_data` in DATA_W: register-file read data.
- `forward_a`, `forward_b` in 2: forward selects from the hazard unit.
- `stall` in 1: hazard unit stall.
- `flush` in 1: squash the instruction entering EX.
- `ex_alu_result` in DATA_W: combinational ALU output of the EX slot.
- `mem_load_data` in DATA_W: load data returned during the MEM slot.
- `ex_rd`, `mem_rd`, `wb_rd` out 2: slot destinations.
- `ex_reg_write`, `mem_reg_write`, `wb_reg_write` out 1: slot write enables, each gated by the slot's valid bit.
- `ex_mem_read` out 1: the EX slot is a valid load.
- `ex_op_a`, `ex_op_b` out DATA_W: registered forwarded operands for the ALU.
- `rf_we` out 1, `rf_waddr` out 2, `rf_wdata` out DATA_W: register-file write port.
- `stall_count` out 16: present only with `HPT_STALL_CNT_EN`.

## Operation
- Forward encoding:
  - 00 selects register-file data.
  - 11 selects `ex_alu_result`.
  - 01 selects the MEM value: `mem_load_data` if the MEM slot is a load, otherwise the MEM result register.
  - 10 selects the WB result register.
- **EX capture**, when `id_valid & !stall & !flush`:
  - EX slot takes `id_rd`, `id_reg_write`, `id_mem_read`, `valid=1`.
  - `ex_op_a` and `ex_op_b` take the muxed operands.
- **Bubble**, when `stall | flush | !id_valid`:
  - EX slot takes `valid=0`, `reg_write=0`, `mem_read=0`.
  - `ex_op_a` and `ex_op_b` hold their previous values (don't-care).
- **Advance**: MEM and WB always advance every cycle. Stall only affects EX capture, because the upstream ID stage holds itself.
  - MEM result register takes `ex_alu_result`.
  - WB result register takes the MEM value (load data or ALU result).
- **Write-back**:
  - `rf_we = wb_valid & wb_reg_write`.
  - `rf_waddr = wb_rd`.
  - `rf_wdata` = WB result.
- **Simultaneous events**:
  - `flush` together with `stall`: bubble.
  - `flush` does not affect MEM or WB.
- **Width**: all datapaths are DATA_W. No arithmetic is done in this block.

## Timing
- **Reset**: every valid, reg_write and mem_read bit is 0; all rd fields are 0; all data registers are 0. Therefore every output is 0 while `rst_n` is low and in the first cycle after release.
- **Reset mid-operation**: the pipeline empties immediately and asynchronously, and no write-back occurs.
- **Latency**:
  - Operands are latched one edge after decode.
  - An instruction reaches MEM on the 2nd edge, WB on the 3rd edge, and drives `rf_we` during the cycle after the 3rd edge.
- **Load-use**: while stall is high the EX slot is a bubble. The load reaches MEM, and on the next edge `forward=01` selects `mem_load_data`.
- All outputs are registered, except the ones derived combinationally from slot registers (gated enables and `rf_*`).

## Configuration
- `HPT_STALL_CNT_EN` defined:
  - 16-bit `stall_count` increments on every edge where `stall` is high.
  - Saturates at 0xFFFF.
  - Reset to 0.
- Macro undefined: the port and the counter are absent.

## Structure
- Shared package `pipe_pkg`:
  - `REG_ADDR_W = 2`.
  - Forward-select enum: `FWD_RF = 2'b00`, `FWD_MEM = 2'b01`, `FWD_WB = 2'b10`, `FWD_EX = 2'b11`.
  - Slot struct: `valid`, `rd`, `reg_write`, `mem_read`.
- Sub-module `pipe_slot_reg`: a slot struct register with async reset and a bubble input. It is instantiated three times (EX, MEM, WB).

## Test plan
1. Reset, then a single instruction: rd=2, reg_write=1, alu=0x1234 → `rf_we`=1, `rf_waddr`=2, `rf_wdata`=0x1234 in the cycle after the 3rd edge. No other `rf_we` pulses.
2. Back-to-back dependency with `forward_a`=11, `ex_alu_result`=0x00AA → `ex_op_a`=0x00AA after the edge. Repeat with 01 (MEM ALU value) and 10 (WB value).
3. Load then use: `ex_mem_read`=1, stall=1 for one cycle → EX bubble (`ex_reg_write`=0). Next cycle `forward_b`=01 with `mem_load_data`=0xBEEF → `ex_op_b`=0xBEEF.
4. `flush` and `stall` asserted together on a valid instruction → EX valid=0. The older MEM/WB instructions still write back.
5. `IGNORE_REG0`=1 with rd=0 and reg_write=1 → `ex_reg_write`=0 and no `rf_we`. `rst_n` low mid-stream → all outputs 0 immediately.
6. With `HPT_STALL_CNT_EN` defined, hold stall for 70000 cycles → `stall_count` = 0xFFFF and holds.

Source files
------------

// File: rtl/hazard_pipe_tracker_pkg.sv
// Shared pipeline types for hazard_pipe_tracker: the slot struct and forward-select encoding.
package pipe_pkg;

    localparam int REG_ADDR_W = 2;

    typedef enum logic [1:0] {
        FWD_RF  = 2'b00,
        FWD_MEM = 2'b01,
        FWD_WB  = 2'b10,
        FWD_EX  = 2'b11
    } fwd_e;

    typedef struct packed {
        logic                  valid;
        logic [REG_ADDR_W-1:0] rd;
        logic                  reg_write;
        logic                  mem_read;
    } slot_t;

endpackage

// File: rtl/hazard_pipe_tracker_slot.sv
// One pipeline slot register (EX, MEM or WB) with async reset and a bubble input.
module pipe_slot_reg
    import pipe_pkg::*;
(
    input  logic  clk_i,
    input  logic  rst_n_i,
    input  logic  bubble_i,
    input  slot_t slot_i,
    output slot_t slot_o
);

    slot_t slot_q;

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            slot_q <= '0;
        end else if (bubble_i) begin
            slot_q <= '0;
        end else begin
            slot_q <= slot_i;
        end
    end

    assign slot_o = slot_q;

endmodule

// File: rtl/hazard_pipe_tracker.sv
// EX/MEM/WB slot tracker with operand forwarding and register-file write port.
// Optional HPT_STALL_CNT_EN adds a saturating 16-bit stall counter output.
module hazard_pipe_tracker
    import pipe_pkg::*;
#(
    parameter int DATA_W      = 16,
    parameter int IGNORE_REG0 = 0
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  id_valid,
    input  logic [REG_ADDR_W-1:0] id_rd,
    input  logic                  id_reg_write,
    input  logic                  id_mem_read,
    input  logic [DATA_W-1:0]     id_rs_data,
    input  logic [DATA_W-1:0]     id_rt_data,
    input  logic [1:0]            forward_a,
    input  logic [1:0]            forward_b,
    input  logic                  stall,
    input  logic                  flush,
    input  logic [DATA_W-1:0]     ex_alu_result,
    input  logic [DATA_W-1:0]     mem_load_data,
    output logic [REG_ADDR_W-1:0] ex_rd,
    output logic [REG_ADDR_W-1:0] mem_rd,
    output logic [REG_ADDR_W-1:0] wb_rd,
    output logic                  ex_reg_write,
    output logic                  mem_reg_write,
    output logic                  wb_reg_write,
    output logic                  ex_mem_read,
    output logic [DATA_W-1:0]     ex_op_a,
    output logic [DATA_W-1:0]     ex_op_b,
    output logic                  rf_we,
    output logic [REG_ADDR_W-1:0] rf_waddr,
    output logic [DATA_W-1:0]     rf_wdata
`ifdef HPT_STALL_CNT_EN
    ,
    output logic [15:0]           stall_count
`endif
);

    slot_t ex_s, mem_s, wb_s, ex_d;
    logic  capture;
    logic  unused_wb_mem_read;
    logic [DATA_W-1:0] op_a_q, op_b_q, op_a_d, op_b_d;
    logic [DATA_W-1:0] mem_res_q, wb_res_q, mem_val;

    function automatic logic [DATA_W-1:0] fwd_sel(
        input logic [1:0]        sel,
        input logic [DATA_W-1:0] rf,
        input logic [DATA_W-1:0] mem,
        input logic [DATA_W-1:0] wb,
        input logic [DATA_W-1:0] ex
    );
        logic [DATA_W-1:0] r;
        r = rf;
        unique case (fwd_e'(sel))
            FWD_RF:  r = rf;
            FWD_MEM: r = mem;
            FWD_WB:  r = wb;
            FWD_EX:  r = ex;
            default: r = rf;
        endcase
        return r;
    endfunction

    assign capture = id_valid & ~stall & ~flush;

    always_comb begin
        ex_d           = '0;
        ex_d.valid     = 1'b1;
        ex_d.rd        = id_rd;
        ex_d.reg_write = id_reg_write
                       & ~((IGNORE_REG0 != 0) && (id_rd == '0));
        ex_d.mem_read  = id_mem_read;
    end

    pipe_slot_reg u_ex (
        .clk_i    (clk),
        .rst_n_i  (rst_n),
        .bubble_i (~capture),
        .slot_i   (ex_d),
        .slot_o   (ex_s)
    );

    pipe_slot_reg u_mem (
        .clk_i    (clk),
        .rst_n_i  (rst_n),
        .bubble_i (1'b0),
        .slot_i   (ex_s),
        .slot_o   (mem_s)
    );

    pipe_slot_reg u_wb (
        .clk_i    (clk),
        .rst_n_i  (rst_n),
        .bubble_i (1'b0),
        .slot_i   (mem_s),
        .slot_o   (wb_s)
    );

    // A load in MEM exposes its returned data instead of the address result.
    assign mem_val = (mem_s.valid & mem_s.mem_read) ? mem_load_data : mem_res_q;

    assign op_a_d = fwd_sel(forward_a, id_rs_data, mem_val, wb_res_q, ex_alu_result);
    assign op_b_d = fwd_sel(forward_b, id_rt_data, mem_val, wb_res_q, ex_alu_result);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op_a_q    <= '0;
            op_b_q    <= '0;
            mem_res_q <= '0;
            wb_res_q  <= '0;
        end else begin
            if (capture) begin
                op_a_q <= op_a_d;
                op_b_q <= op_b_d;
            end
            mem_res_q <= ex_alu_result;
            wb_res_q  <= mem_val;
        end
    end

`ifdef HPT_STALL_CNT_EN
    logic [15:0] stall_cnt_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cnt_q <= '0;
        end else if (stall && (stall_cnt_q != 16'hFFFF)) begin
            stall_cnt_q <= stall_cnt_q + 16'd1;
        end
    end

    assign stall_count = stall_cnt_q;
`endif

    assign ex_rd         = ex_s.rd;
    assign mem_rd        = mem_s.rd;
    assign wb_rd         = wb_s.rd;
    assign ex_reg_write  = ex_s.valid & ex_s.reg_write;
    assign mem_reg_write = mem_s.valid & mem_s.reg_write;
    assign wb_reg_write  = wb_s.valid & wb_s.reg_write;
    assign ex_mem_read   = ex_s.valid & ex_s.mem_read;
    assign ex_op_a       = op_a_q;
    assign ex_op_b       = op_b_q;
    assign rf_we         = wb_s.valid & wb_s.reg_write;
    assign rf_waddr      = wb_s.rd;
    assign rf_wdata      = wb_res_q;

    assign unused_wb_mem_read = wb_s.mem_read;

endmodule
